id_decode_pipe_stage: RTL
=========================

// Module: id_decode_pipe_stage
// PURPOSE
//   Parametrised decode stage with its own ID/EX output register, internal register file,
//   condition check, RAW hazard detection and a valid/ready handshake to IF.
//   Sits between the IF/ID register and EX. Stalls or flushes without external freeze glue.
//   One-cycle latency from an accepted instruction to registered EX-side outputs.
// PARAMETERS
//   WORD_WIDTH     32  data width of register-file entries, pc and val_Rn/val_Rm
//   REG_COUNT      16  implemented registers (1..16); index >= REG_COUNT reads 0, writes dropped
//   HAZARD_STAGES   2  1: compare sources against EX dst only; 2: against EX and MEM dst
// PORTS
//   clk              in   1    clock, rising edge
//   rst              in   1    asynchronous, active-high reset
//   in_valid         in   1    IF/ID holds a valid instruction
//   in_ready         out  1    stage accepts instruction this cycle (combinational)
//   instruction_in   in   32   ARM-format instruction
//   pc_in            in   WORD_WIDTH  pc of instruction_in
//   status_register  in   4    {N,Z,C,V} for the condition check
//   flush            in   1    branch taken in EX: discard current instruction
//   ex_wb_en/ex_dst  in   1/4  destination of instruction in EX
//   mem_wb_en/mem_dst in  1/4  destination of instruction in MEM
//   wb_en/wb_addr/wb_data in 1/4/WORD_WIDTH  register-file write port
//   out_valid        out  1    ID/EX register holds a real instruction
//   ctrl_out         out  9    {SR_update,B,EX_command[3:0],mem_write,mem_read,WB_en}
//   imm_out, has_src1, has_src2  out 1 each
//   src1, src2, dst  out  4    register indices (Rn, Rm or Rd for stores, Rd)
//   shifter_operand  out  12   instr[11:0];  signed_immediate out 24  instr[23:0]
//   pc, val_Rn, val_Rm  out  WORD_WIDTH each
// BEHAVIOUR
//   - Reset: every output register and every register-file entry is 0; out_valid=0.
//   - Decode (comb): mode=instr[27:26], opcode=instr[24:21], S=instr[20], I=instr[25];
//     EX_command per the team ARM opcode table; src2=instr[15:12] when mem_write, else instr[3:0];
//     has_src2 = ~I | mem_write; has_src1 = 0 for MOV/MVN and branch.
//   - Condition fail: ctrl bits = 0, out_valid = 1 (instruction retires as a no-op).
//   - hazard = in_valid & ((has_src1 & match(src1)) | (has_src2 & match(src2)));
//     match(r) = (ex_wb_en & ex_dst==r) | (HAZARD_STAGES==2 & mem_wb_en & mem_dst==r).
//   - Priority per rising edge: flush > hazard > accept > idle.
//     flush: load bubble (out_valid=0, ctrl=0); in_ready=1 (instruction dropped).
//     hazard: load bubble; in_ready=0 (IF holds); re-evaluated each cycle.
//     accept (in_valid & ~hazard): load decoded fields, operands and pc; out_valid=1.
//     idle (~in_valid): load bubble.
//   - Bubble clears ctrl_out and out_valid only; data fields are don't-care.
//   - Register file: write on rising edge when wb_en & wb_addr<REG_COUNT; two async read ports.
//   - rst asserted mid-stall or mid-flush: outputs and regfile go to 0 immediately;
//     in_ready=1 once rst deasserts.
// CONFIGURATION
//   ID_WB_BYPASS_EN defined: if wb_en and wb_addr equals the read address in the same
//     cycle, val_Rn/val_Rm capture wb_data (write-through). MEM/WB hazard needs no stall.
//   Undefined: a read in the write cycle returns the old value. The bench must then
//     exercise the HAZARD_STAGES=2 stall path to cover that case.
// TESTING
//   1. rst pulse mid-run -> all outputs 0, out_valid=0, R0..R15 read 0 next cycle.
//   2. wb R3=0x12345678, then ADD R1,R3,R3 (AL) -> next cycle ctrl EX_command=0010,
//      WB_en=1, val_Rn=val_Rm=0x12345678, out_valid=1.
//   3. ex_wb_en=1, ex_dst=2, SUB R4,R2,#1 -> in_ready=0, bubble for the cycle; ex_wb_en=0
//      -> accepted the following cycle.
//   4. flush=1 with a hazard present -> in_ready=1, out_valid=0, instruction dropped.
//   5. ADDEQ with Z=0 -> out_valid=1, ctrl_out=9'b0.
//   6. wb_en R5=0xA5 in the same cycle as a read of R5 -> val_Rn=0xA5 with ID_WB_BYPASS_EN,
//      else the old R5 value.

Source files
------------

// File: rtl/id_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// id_decode_pipe_stage
//   Instruction-decode stage for a five-stage ARM-subset pipeline. It has its
//   own ID/EX output register and an internal register file. It also does the
//   condition-code check and RAW hazard detection against EX (and MEM), and it
//   runs a valid/ready handshake towards IF. The stage stalls or flushes
//   without any external freeze logic.
//
//   Handshake: IF presents an instruction with in_valid. The instruction is
//   consumed on a rising edge where in_valid & in_ready. in_ready is
//   combinational: it drops only while a RAW hazard exists and no flush is
//   requested. A flush drops the presented instruction and keeps in_ready high.
//
//   Optional feature (macro ID_WB_BYPASS_EN): when the register-file write
//   port targets a register that is being read in the same cycle, the read
//   returns wb_data (write-through). When the macro is absent, a read in the
//   write cycle returns the old value.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid / in_ready      handshake with the IF/ID register
//   instruction_in, pc_in    instruction word and its pc
//   status_register          {N,Z,C,V} flags for the condition check
//   flush                    branch taken in EX: drop the current instruction
//   ex_wb_en/ex_dst          destination of the instruction in EX
//   mem_wb_en/mem_dst        destination of the instruction in MEM
//   wb_en/wb_addr/wb_data    register-file write port
//   out_valid, ctrl_out      ID/EX valid and {SR_update,B,EX_cmd[3:0],mem_w,mem_r,WB_en}
//   imm_out, has_src1/2      immediate flag, source-use flags
//   src1, src2, dst          register indices
//   shifter_operand          instr[11:0]
//   signed_immediate         instr[23:0]
//   pc, val_Rn, val_Rm       pc and operand values
// ---------------------------------------------------------------------------
module id_decode_pipe_stage #(
  parameter int WORD_WIDTH    = 32,
  parameter int REG_COUNT     = 16,
  parameter int HAZARD_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction_in,
  input  logic [WORD_WIDTH-1:0] pc_in,
  input  logic [3:0]            status_register,
  input  logic                  flush,
  input  logic                  ex_wb_en,
  input  logic [3:0]            ex_dst,
  input  logic                  mem_wb_en,
  input  logic [3:0]            mem_dst,
  input  logic                  wb_en,
  input  logic [3:0]            wb_addr,
  input  logic [WORD_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  output logic [8:0]            ctrl_out,
  output logic                  imm_out,
  output logic                  has_src1,
  output logic                  has_src2,
  output logic [3:0]            src1,
  output logic [3:0]            src2,
  output logic [3:0]            dst,
  output logic [11:0]           shifter_operand,
  output logic [23:0]           signed_immediate,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] val_Rn,
  output logic [WORD_WIDTH-1:0] val_Rm
);

  localparam logic [4:0] LP_RC      = 5'(REG_COUNT);
  localparam logic       LP_MEM_CHK = (HAZARD_STAGES == 2);

  // Instruction fields
  logic [3:0] w_cond, w_opcode;
  logic [1:0] w_mode;
  logic       w_imm, w_s;
  assign w_cond   = instruction_in[31:28];
  assign w_mode   = instruction_in[27:26];
  assign w_imm    = instruction_in[25];
  assign w_opcode = instruction_in[24:21];
  assign w_s      = instruction_in[20];

  // Control decode
  logic [3:0] w_ex_cmd;
  logic       w_sr, w_b, w_mem_r, w_mem_w, w_wb, w_no_rn;
  always_comb begin
    w_ex_cmd = 4'b0000;
    w_sr     = 1'b0;
    w_b      = 1'b0;
    w_mem_r  = 1'b0;
    w_mem_w  = 1'b0;
    w_wb     = 1'b0;
    w_no_rn  = 1'b0;
    case (w_mode)
      2'b00: begin
        w_sr = w_s;
        case (w_opcode)
          4'b1101: begin w_ex_cmd = 4'b0001; w_wb = 1'b1; w_no_rn = 1'b1; end // MOV
          4'b1111: begin w_ex_cmd = 4'b1001; w_wb = 1'b1; w_no_rn = 1'b1; end // MVN
          4'b0100: begin w_ex_cmd = 4'b0010; w_wb = 1'b1; end                 // ADD
          4'b0101: begin w_ex_cmd = 4'b0011; w_wb = 1'b1; end                 // ADC
          4'b0010: begin w_ex_cmd = 4'b0100; w_wb = 1'b1; end                 // SUB
          4'b0110: begin w_ex_cmd = 4'b0101; w_wb = 1'b1; end                 // SBC
          4'b0000: begin w_ex_cmd = 4'b0110; w_wb = 1'b1; end                 // AND
          4'b1100: begin w_ex_cmd = 4'b0111; w_wb = 1'b1; end                 // ORR
          4'b0001: begin w_ex_cmd = 4'b1000; w_wb = 1'b1; end                 // EOR
          4'b1010: w_ex_cmd = 4'b0100;                                        // CMP
          4'b1000: w_ex_cmd = 4'b0110;                                        // TST
          default: w_sr = 1'b0;  // unsupported opcode retires as a no-op
        endcase
      end
      2'b01: begin  // LDR when S=1, STR when S=0; both add the offset
        w_ex_cmd = 4'b0010;
        w_mem_r  = w_s;
        w_mem_w  = ~w_s;
        w_wb     = w_s;
      end
      2'b10: begin
        w_b     = 1'b1;
        w_no_rn = 1'b1;
      end
      default: ;
    endcase
  end

  // Condition check; cond 4'b1111 is treated like AL
  logic w_n, w_z, w_c, w_v, w_cond_ok;
  assign {w_n, w_z, w_c, w_v} = status_register;
  always_comb begin
    w_cond_ok = 1'b1;
    case (w_cond)
      4'h0: w_cond_ok = w_z;
      4'h1: w_cond_ok = ~w_z;
      4'h2: w_cond_ok = w_c;
      4'h3: w_cond_ok = ~w_c;
      4'h4: w_cond_ok = w_n;
      4'h5: w_cond_ok = ~w_n;
      4'h6: w_cond_ok = w_v;
      4'h7: w_cond_ok = ~w_v;
      4'h8: w_cond_ok = w_c & ~w_z;
      4'h9: w_cond_ok = ~w_c | w_z;
      4'hA: w_cond_ok = (w_n == w_v);
      4'hB: w_cond_ok = (w_n != w_v);
      4'hC: w_cond_ok = ~w_z & (w_n == w_v);
      4'hD: w_cond_ok = w_z | (w_n != w_v);
      default: w_cond_ok = 1'b1;
    endcase
  end

  logic [8:0] w_ctrl;
  assign w_ctrl = w_cond_ok ? {w_sr, w_b, w_ex_cmd, w_mem_w, w_mem_r, w_wb} : 9'b0;

  // Operand indices; stores read Rd as the data source
  logic [3:0] w_src1, w_src2;
  logic       w_has_src1, w_has_src2;
  assign w_src1     = instruction_in[19:16];
  assign w_src2     = w_mem_w ? instruction_in[15:12] : instruction_in[3:0];
  assign w_has_src1 = ~w_no_rn;
  assign w_has_src2 = ~w_imm | w_mem_w;

  // Hazard detection
  logic w_match1, w_match2, w_hazard;
  assign w_match1 = (ex_wb_en & (ex_dst == w_src1)) |
                    (LP_MEM_CHK & mem_wb_en & (mem_dst == w_src1));
  assign w_match2 = (ex_wb_en & (ex_dst == w_src2)) |
                    (LP_MEM_CHK & mem_wb_en & (mem_dst == w_src2));
  assign w_hazard = in_valid & ((w_has_src1 & w_match1) | (w_has_src2 & w_match2));
  assign in_ready = flush | ~w_hazard;

  // Register file: 16 slots are declared, and slots at or above REG_COUNT are
  // never written and never read, so only REG_COUNT of them are real.
  logic [WORD_WIDTH-1:0] r_rf [16];
  logic                  w_wb_ok;
  assign w_wb_ok = wb_en & ({1'b0, wb_addr} < LP_RC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else if (w_wb_ok) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  logic [WORD_WIDTH-1:0] w_rd1, w_rd2, w_val_rn, w_val_rm;
  assign w_rd1 = ({1'b0, w_src1} < LP_RC) ? r_rf[w_src1] : '0;
  assign w_rd2 = ({1'b0, w_src2} < LP_RC) ? r_rf[w_src2] : '0;
`ifdef ID_WB_BYPASS_EN
  assign w_val_rn = (w_wb_ok && wb_addr == w_src1) ? wb_data : w_rd1;
  assign w_val_rm = (w_wb_ok && wb_addr == w_src2) ? wb_data : w_rd2;
`else
  assign w_val_rn = w_rd1;
  assign w_val_rm = w_rd2;
`endif

  // ID/EX register. A bubble clears only out_valid and ctrl_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      ctrl_out         <= '0;
      imm_out          <= 1'b0;
      has_src1         <= 1'b0;
      has_src2         <= 1'b0;
      src1             <= '0;
      src2             <= '0;
      dst              <= '0;
      shifter_operand  <= '0;
      signed_immediate <= '0;
      pc               <= '0;
      val_Rn           <= '0;
      val_Rm           <= '0;
    end else if (flush | w_hazard | ~in_valid) begin
      out_valid <= 1'b0;
      ctrl_out  <= '0;
    end else begin
      out_valid        <= 1'b1;
      ctrl_out         <= w_ctrl;
      imm_out          <= w_imm;
      has_src1         <= w_has_src1;
      has_src2         <= w_has_src2;
      src1             <= w_src1;
      src2             <= w_src2;
      dst              <= instruction_in[15:12];
      shifter_operand  <= instruction_in[11:0];
      signed_immediate <= instruction_in[23:0];
      pc               <= pc_in;
      val_Rn           <= w_val_rn;
      val_Rm           <= w_val_rm;
    end
  end

endmodule
